// File: rtl/ball_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ball_pkg: shared types and constants for the handball court control. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    MOVE_R = 3'd2,
    MOVE_L = 3'd3,
    POINT  = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic       LEFT      = 1'b0;
  localparam logic       RIGHT     = 1'b1;
  localparam logic [1:0] SPEED_MAX = 2'd3;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_tick_gen: clock-enable divider with clear and variable period. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module shift_tick_gen #(
  parameter int DIV_W = 26
) (
  input  logic             CLKIN,
  input  logic             RSTN,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             SHIFT_TICK
);

  localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

  logic [DIV_W-1:0] r_count;
  logic             w_last;

  // >= rather than == so a shortened period can never strand the count above it
  assign w_last     = (r_count >= (period - c_ONE));
  assign SHIFT_TICK = w_last;

  always_ff @(posedge CLKIN or negedge RSTN) begin
    if (!RSTN) begin
      r_count <= '0;
    end else if (clr || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ball_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ball_shift_ctrl: handball LED court game FSM, paddles and scoring.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ball_shift_ctrl
  import ball_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int BASE_DIV   = 50000,
  parameter int DIV_W      = 26,
  parameter int WIN_SCORE  = 9,
  parameter int HOLD_TICKS = 2
) (
  input  logic             CLKIN,
  input  logic             RSTN,
  input  logic             START,
  input  logic             BTN_L,
  input  logic             BTN_R,
  output logic [N_LED-1:0] LED,
  output logic [3:0]       SCORE_L,
  output logic [3:0]       SCORE_R,
  output logic [1:0]       SPEED,
  output logic             SHIFT_TICK,
  output logic             GAME_OVER
);

  localparam int               POS_W       = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [POS_W-1:0] c_POS_MAX   = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] c_POS_ONE   = POS_W'(1);
  localparam logic [3:0]       c_WIN       = 4'(WIN_SCORE);
  localparam logic [3:0]       c_HOLD_LAST = 4'(HOLD_TICKS - 1);
  localparam logic [DIV_W-1:0] c_BASE      = DIV_W'(BASE_DIV);
  localparam logic [N_LED-1:0] c_LED_LSB   = N_LED'(1);

  state_t           r_state, w_state_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  logic [1:0]       r_speed, w_speed_nxt;
  logic [3:0]       r_score_l, w_score_l_nxt, r_score_r, w_score_r_nxt;
  logic [3:0]       r_hold, w_hold_nxt;
  logic             r_server, w_server_nxt;
  logic             r_start_d, r_btnl_d, r_btnr_d;
  logic             w_rise_s, w_rise_l, w_rise_r;
  logic             w_hit, w_pt_l, w_pt_r, w_clr, w_tick, w_moving;
  logic [DIV_W-1:0] w_period;

  assign w_rise_s = START & ~r_start_d;
  assign w_rise_l = BTN_L & ~r_btnl_d;
  assign w_rise_r = BTN_R & ~r_btnr_d;
  assign w_moving = (r_state == MOVE_R) || (r_state == MOVE_L);
  assign w_period = w_moving ? (c_BASE >> r_speed) : c_BASE;
  // The divider only runs while the ball moves or the point display blinks
  assign w_clr    = (w_state_nxt != r_state) || w_hit || !(w_moving || (r_state == POINT));

  shift_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .CLKIN      (CLKIN),
    .RSTN       (RSTN),
    .clr        (w_clr),
    .period     (w_period),
    .SHIFT_TICK (w_tick)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_speed_nxt   = r_speed;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_server_nxt  = r_server;
    w_hold_nxt    = r_hold;
    w_hit         = 1'b0;
    w_pt_l        = 1'b0;
    w_pt_r        = 1'b0;
    if (w_rise_s) begin
      w_state_nxt   = SERVE;
      w_pos_nxt     = '0;
      w_speed_nxt   = '0;
      w_score_l_nxt = '0;
      w_score_r_nxt = '0;
      w_server_nxt  = LEFT;
      w_hold_nxt    = '0;
    end else begin
      case (r_state)
        SERVE: begin
          if (r_server == LEFT && w_rise_l) begin
            w_state_nxt = MOVE_R;
            w_speed_nxt = '0;
          end else if (r_server == RIGHT && w_rise_r) begin
            w_state_nxt = MOVE_L;
            w_speed_nxt = '0;
          end
        end
        MOVE_R: begin
          if (w_rise_r) begin
            if (r_pos == c_POS_MAX) begin
              w_hit       = 1'b1;
              w_state_nxt = MOVE_L;
              w_speed_nxt = (r_speed == SPEED_MAX) ? SPEED_MAX : r_speed + 2'd1;
            end else begin
              w_pt_l = 1'b1;
            end
          end else if (w_tick) begin
            if (r_pos == c_POS_MAX) w_pt_l = 1'b1;
            else                    w_pos_nxt = r_pos + c_POS_ONE;
          end
        end
        MOVE_L: begin
          if (w_rise_l) begin
            if (r_pos == '0) begin
              w_hit       = 1'b1;
              w_state_nxt = MOVE_R;
              w_speed_nxt = (r_speed == SPEED_MAX) ? SPEED_MAX : r_speed + 2'd1;
            end else begin
              w_pt_r = 1'b1;
            end
          end else if (w_tick) begin
            if (r_pos == '0) w_pt_r = 1'b1;
            else             w_pos_nxt = r_pos - c_POS_ONE;
          end
        end
        POINT: begin
          if (w_tick) begin
            if (r_hold == c_HOLD_LAST) begin
              if (r_score_l == c_WIN || r_score_r == c_WIN) begin
                w_state_nxt = OVER;
              end else begin
                w_state_nxt = SERVE;
                w_pos_nxt   = (r_server == LEFT) ? '0 : c_POS_MAX;
              end
            end else begin
              w_hold_nxt = r_hold + 4'd1;
            end
          end
        end
        default: ;
      endcase
      if (w_pt_l) begin
        w_state_nxt   = POINT;
        w_score_l_nxt = sat_inc(r_score_l, c_WIN);
        w_server_nxt  = RIGHT;
        w_hold_nxt    = '0;
      end
      if (w_pt_r) begin
        w_state_nxt   = POINT;
        w_score_r_nxt = sat_inc(r_score_r, c_WIN);
        w_server_nxt  = LEFT;
        w_hold_nxt    = '0;
      end
    end
  end

  always_ff @(posedge CLKIN or negedge RSTN) begin
    if (!RSTN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLKIN or negedge RSTN) begin
    if (!RSTN) begin
      r_pos     <= '0;
      r_speed   <= '0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_server  <= LEFT;
      r_hold    <= '0;
      r_start_d <= 1'b0;
      r_btnl_d  <= 1'b0;
      r_btnr_d  <= 1'b0;
    end else begin
      r_pos     <= w_pos_nxt;
      r_speed   <= w_speed_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
      r_server  <= w_server_nxt;
      r_hold    <= w_hold_nxt;
      r_start_d <= START;
      r_btnl_d  <= BTN_L;
      r_btnr_d  <= BTN_R;
    end
  end

  always_comb begin
    LED = '0;
    case (r_state)
      SERVE, MOVE_R, MOVE_L: LED = c_LED_LSB << r_pos;
      POINT:                 LED = r_hold[0] ? '0 : '1;
      OVER:                  LED = '1;
      default:               LED = '0;
    endcase
  end

  assign SCORE_L    = r_score_l;
  assign SCORE_R    = r_score_r;
  assign SPEED      = r_speed;
  assign SHIFT_TICK = w_tick;
  assign GAME_OVER  = (r_state == OVER);

endmodule
`default_nettype wire
